// File: rtl/sort6_seq_ctrl.sv
// sort6_seq_ctrl: loads six bytes one at a time, then runs one compare-exchange
// pass per clock until the bytes are sorted, then streams them out smallest first.

// One compare-exchange cell of the pass network. The larger value moves on as
// the carry. Equal values are not swapped, which keeps the sort stable.
module sort6_cx_cell #(
    parameter int W = 8
) (
    input  logic [W-1:0] c_in,
    input  logic [W-1:0] e,
    output logic [W-1:0] lo,
    output logic [W-1:0] c_out,
    output logic         swap
);
    // A swap happens only when the carry is strictly greater than the element
    always_comb begin
        swap  = (c_in > e);
        lo    = swap ? e : c_in;
        c_out = swap ? c_in : e;
    end
endmodule

module sort6_seq_ctrl #(
    parameter int W        = 8,
    parameter int N        = 6,
    parameter int MAX_PASS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic [2:0]   pass_cnt
);
    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    localparam logic [2:0] LAST_IDX = 3'(N - 1);
    localparam logic [2:0] PASS_LIM = 3'(MAX_PASS);

    state_t                  state, state_nxt;
    logic [2:0]              idx;
    logic [N-1:0][W-1:0]     e_q;
    logic [N-1:0][W-1:0]     pass_e;
    logic [N-1:0][W-1:0]     carry;
    logic [N-2:0]            swp;
    logic                    any_swap;
    logic [2:0]              pass_nxt;
    logic                    in_fire, out_fire;

    // Pass network: carry chain of N-1 cells, carry starts from lane 0
    assign carry[0] = e_q[0];
    for (genvar k = 1; k < N; k++) begin : g_cell
        sort6_cx_cell #(.W(W)) u_cell (
            .c_in  (carry[k-1]),
            .e     (e_q[k]),
            .lo    (pass_e[k-1]),
            .c_out (carry[k]),
            .swap  (swp[k-1])
        );
    end
    assign pass_e[N-1] = carry[N-1];
    assign any_swap    = |swp;
    assign pass_nxt    = pass_cnt + 3'd1;

    // Handshake outputs decode straight from state so reset clears them at once
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        state_nxt = state;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == LAST_IDX) state_nxt = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (!any_swap || pass_nxt == PASS_LIM) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = e_q[idx];
                out_last  = (idx == LAST_IDX);
                if (out_ready && idx == LAST_IDX) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Element store, index and pass counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            idx      <= '0;
            pass_cnt <= '0;
        end else begin
            unique case (state)
                LOAD: if (in_fire) begin
                    e_q[idx] <= in_data;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        pass_cnt <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                SORT: begin
                    e_q      <= pass_e;
                    pass_cnt <= pass_nxt;
                end
                DRAIN: if (out_fire) begin
                    idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                end
                default: idx <= '0;
            endcase
        end
    end
endmodule

// File: doc/sort6_seq_ctrl.md
Name: sort6_seq_ctrl

Overview:
- Sequencing controller for the 6-lane, 8-bit compare-exchange pass network: one pass moves the larger value of each adjacent pair rightward, so lane 5 receives the maximum.
- Accepts six bytes serially, applies one pass per clock until sorted (early exit on a swap-free pass), then streams the ascending result out serially.
- Sits between a byte-stream producer and consumer; the pass datapath is instantiated inside the block.

Parameters:
- W, 8, data width per element.
- N, 6, element count; fixed at 6, matching the pass network lane count.
- MAX_PASS, 5, pass limit (N-1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a byte
- in_ready  out  1  block accepts a byte this cycle
- in_data  in  W  input byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  W  sorted byte, smallest first
- out_last  out  1  high with the 6th output byte
- busy  out  1  high in SORT and DRAIN
- pass_cnt  out  3  passes executed in the current or most recent sort

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state registers on posedge clk / negedge rst_n.
- Reset values: state=LOAD, element regs e0..e5=0, idx=0, pass_cnt=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Reset mid-operation (any state) aborts immediately, discards data, returns to the reset values; no partial output.
- FSM: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: e[idx]<=in_data, idx++.
  - The accept at idx=5 moves to SORT with idx<=0 and pass_cnt<=0.
  - in_valid low holds state.
- SORT:
  - in_ready=0, busy=1. in_valid is ignored; no byte is consumed.
  - Each cycle the pass result is written back to e0..e5 and pass_cnt++.
  - Pass rule, applied left to right with carry: c=e0; for k=1..5, lane k-1 gets min(c,ek) and c=max(c,ek); lane 5 gets c.
  - A swap occurs only when strictly greater; equal values do not swap, so the sort is stable.
  - Exit to DRAIN when the pass performed no swap or when pass_cnt reaches MAX_PASS after the increment.
  - The minimum is 1 SORT cycle, even for already-sorted input.
- DRAIN:
  - out_valid=1, out_data=e[idx], out_last=(idx==5), busy=1.
  - On out_valid&out_ready: idx++.
  - The handshake at idx=5 returns to LOAD with idx<=0.
  - out_ready low holds out_data stable (no change while valid&!ready).
  - in_ready=0.
- pass_cnt holds its final value through DRAIN and the next LOAD; it clears only on entry to SORT.
- Latency: the cycle after the 6th input accept is the first SORT cycle; out_valid rises the cycle after the final SORT cycle.
- Back-to-back: a new LOAD accept is allowed in the cycle right after the last output handshake (in_ready=1 that cycle).
- Arithmetic: unsigned W-bit comparison only; no width growth.

Test Plan:
- Reset: assert rst_n=0 mid-DRAIN after 2 outputs -> out_valid=0, in_ready=1, pass_cnt=0 asynchronously. After release, a full 6-byte load starts from e0.
- Reverse input 60,50,40,30,20,10 with out_ready=1 -> exactly 5 SORT cycles (pass_cnt=5). Output 10,20,30,40,50,60; out_last only on 60.
- Sorted input 1,2,3,4,5,6 -> 1 SORT cycle, pass_cnt=1, output identical to input.
- Duplicates and extremes 255,0,7,7,255,0 -> output 0,0,7,7,255,255. Equal bytes are not swapped; pass_cnt stays at or below 5.
- Backpressure: toggle out_ready 1,0,0,1,... in DRAIN -> out_data stable while stalled. Six handshakes in ascending order. in_valid=1 held throughout SORT/DRAIN consumes nothing.
- Throughput: two vectors streamed back-to-back -> second load begins the cycle after the first vector's out_last handshake. Both results are correct.
